// File: rtl/regfile_mp.sv
// Parametrised multi-port register file. Reads are combinational. Writes,
// the sequenced initialisation engine, the ready flag and write-collision
// status are all clocked. Includes an optional hardwired zero register and
// same-cycle write-to-read bypass.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int R0_ZERO   = 1,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    output logic                     ready,
    output logic                     wr_conflict,
    output logic [7:0]               conflict_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_val;
    logic              conflict;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;

    assign init_val = (INIT_MODE != 0) ? DATA_W'(ptr) : '0;

    // A collision needs both write ports enabled on the same address while
    // writes are actually being honoured.
    generate
        if (NUM_WR == 2) begin : g_conflict
            assign conflict = (state == RUN) && !init_req && (&we) &&
                              (wa[0 +: ADDR_W] == wa[ADDR_W +: ADDR_W]);
        end else begin : g_no_conflict
            assign conflict = 1'b0;
        end
    endgenerate

    // Control FSM: initialisation sequencing, ready flag and collision status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            ptr          <= '0;
            ready        <= 1'b0;
            wr_conflict  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr         <= ptr + 1'b1;
                    wr_conflict <= 1'b0;
                    if (&ptr) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state        <= INIT;
                        ptr          <= '0;
                        ready        <= 1'b0;
                        wr_conflict  <= 1'b0;
                        conflict_cnt <= '0;
                    end else begin
                        wr_conflict <= conflict;
                        if (conflict && (conflict_cnt != 8'hFF)) begin
                            conflict_cnt <= conflict_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state       <= INIT;
                    ptr         <= '0;
                    ready       <= 1'b0;
                    wr_conflict <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: the init engine fills one entry per cycle. In RUN, the
    // ports are applied in ascending order so port 1 wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[ptr] <= init_val;
            end else if ((state == RUN) && !init_req) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (we[j] && !((R0_ZERO != 0) && (wa[j*ADDR_W +: ADDR_W] == '0))) begin
                        mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Read ports: zero while not ready or on the zero register. Otherwise the
    // value is the array entry, overridden by the highest matching write port
    // when bypass is enabled.
    always_comb begin
        rd      = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr = ra[k*ADDR_W +: ADDR_W];
            rd_val  = '0;
            if (ready && !((R0_ZERO != 0) && (rd_addr == '0))) begin
                rd_val = mem[rd_addr];
                if (BYPASS != 0) begin
                    for (int unsigned j = 0; j < NUM_WR; j++) begin
                        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                            rd_val = wd[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            rd[k*DATA_W +: DATA_W] = rd_val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp. Two builds share one stimulus stream:
// dut_a uses the defaults, and dut_b has BYPASS=0 and INIT_MODE=0. Both are
// compared against a cycle-level reference model of the register file.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [63:0] rd_a, rd_b;
    logic        ready_a, ready_b;
    logic        conf_a, conf_b;
    logic [7:0]  cnt_a, cnt_b;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    bit          m_ready;
    int          m_ptr;
    int          m_cnt;
    bit          m_conf;
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .init_req(init_req), .ra(ra), .rd(rd_a),
        .we(we), .wa(wa), .wd(wd), .ready(ready_a),
        .wr_conflict(conf_a), .conflict_cnt(cnt_a)
    );

    regfile_mp #(.BYPASS(0), .INIT_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .init_req(init_req), .ra(ra), .rd(rd_b),
        .we(we), .wa(wa), .wd(wd), .ready(ready_b),
        .wr_conflict(conf_b), .conflict_cnt(cnt_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected combinational read for one port. Same-cycle writes are
    // forwarded only in the bypass build, with port 1 taking priority.
    function automatic logic [31:0] exp_rd(input bit is_b, input int addr);
        int a0, a1;
        a0 = int'(wa[4:0]);
        a1 = int'(wa[9:5]);
        if (!m_ready || addr == 0) return 32'h0;
        if (!is_b) begin
            if (we[1] && a1 == addr) return wd[63:32];
            if (we[0] && a0 == addr) return wd[31:0];
            return mem_a[addr];
        end
        return mem_b[addr];
    endfunction

    // Model the effect of one rising edge using the inputs currently driven.
    task automatic model_edge();
        int a0, a1;
        a0 = int'(wa[4:0]);
        a1 = int'(wa[9:5]);
        if (rst) begin
            m_ready = 0; m_ptr = 0; m_cnt = 0; m_conf = 0;
        end else if (!m_ready) begin
            mem_a[m_ptr] = 32'(m_ptr);
            mem_b[m_ptr] = 32'h0;
            m_ptr++;
            if (m_ptr == 32) m_ready = 1;
            m_conf = 0;
        end else if (init_req) begin
            m_ready = 0; m_ptr = 0; m_cnt = 0; m_conf = 0;
        end else begin
            m_conf = (we == 2'b11) && (a0 == a1);
            if (m_conf && m_cnt < 255) m_cnt++;
            if (we[0] && a0 != 0) begin mem_a[a0] = wd[31:0];  mem_b[a0] = wd[31:0];  end
            if (we[1] && a1 != 0) begin mem_a[a1] = wd[63:32]; mem_b[a1] = wd[63:32]; end
        end
    endtask

    task automatic step(input bit r, input bit ir, input logic [1:0] w,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
        rst = r; init_req = ir; we = w;
        wa = {a1, a0}; wd = {d1, d0}; ra = {r1, r0};
        #1;
        check_val("rd_a0", rd_a[31:0],  exp_rd(0, int'(r0)));
        check_val("rd_a1", rd_a[63:32], exp_rd(0, int'(r1)));
        check_val("rd_b0", rd_b[31:0],  exp_rd(1, int'(r0)));
        check_val("rd_b1", rd_b[63:32], exp_rd(1, int'(r1)));
        @(posedge clk);
        model_edge();
        #1;
        check_val("ready_a", 32'(ready_a), 32'(m_ready));
        check_val("ready_b", 32'(ready_b), 32'(m_ready));
        check_val("conf_a",  32'(conf_a),  32'(m_conf));
        check_val("conf_b",  32'(conf_b),  32'(m_conf));
        check_val("cnt_a",   32'(cnt_a),   32'(m_cnt));
        check_val("cnt_b",   32'(cnt_b),   32'(m_cnt));
    endtask

    // Random cycle; a small address range makes collisions and bypass hits common.
    task automatic rstep(input bit ir, input int amax);
        logic [4:0] a0, a1, r0, r1;
        a0 = 5'($urandom_range(amax, 0));
        a1 = 5'($urandom_range(amax, 0));
        r0 = ($urandom_range(1, 0) == 1) ? a0 : 5'($urandom_range(31, 0));
        r1 = ($urandom_range(1, 0) == 1) ? a1 : 5'($urandom_range(31, 0));
        step(0, ir, 2'($urandom), a0, a1, $urandom, $urandom, r0, r1);
    endtask

    initial begin
        rst = 1'b1; init_req = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
        m_ready = 0; m_ptr = 0; m_cnt = 0; m_conf = 0;
        @(posedge clk);
        #1;
        check_val("rst_ready", 32'(ready_a), 32'h0);
        check_val("rst_conf",  32'(conf_a),  32'h0);
        check_val("rst_cnt",   32'(cnt_a),   32'h0);

        // Initialisation from reset; writes presented during INIT must be ignored.
        for (int i = 0; i < 40; i++) rstep(0, 31);
        step(0, 0, 2'b00, 0, 0, 0, 0, 5'd5, 5'd31);
        step(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd31);

        // Single write with a same-cycle read, then the following cycle.
        step(0, 0, 2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0, 5'd7, 5'd7);
        step(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);

        // Collision on entry 9, then enough collisions to saturate the counter.
        step(0, 0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h2, 5'd9, 5'd9);
        step(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
        for (int i = 0; i < 300; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(31, 0));
            step(0, 0, 2'b11, a, a, $urandom, $urandom, a, 5'($urandom_range(31, 0)));
        end

        // Writes to the zero register through each port.
        step(0, 0, 2'b01, 5'd0, 5'd3, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
        step(0, 0, 2'b10, 5'd4, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

        // Mixed random traffic with occasional re-initialisation.
        for (int i = 0; i < 400; i++) rstep(($urandom_range(99, 0) == 0), 7);
        for (int i = 0; i < 40; i++) rstep(0, 31);

        // Write entry 3, then request init with writes pending that same cycle.
        step(0, 0, 2'b01, 5'd3, 5'd0, 32'hAA, 32'h0, 5'd3, 5'd3);
        step(0, 1, 2'b11, 5'd3, 5'd5, 32'h55, 32'h66, 5'd3, 5'd5);
        for (int i = 0; i < 34; i++) rstep(0, 7);
        step(0, 0, 2'b00, 0, 0, 0, 0, 5'd3, 5'd5);

        // Reset while INIT is in progress restarts the full sequence.
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) rstep(0, 31);
        step(1, 1, 2'b11, 5'd2, 5'd2, 32'h1, 32'h2, 5'd2, 5'd2);
        for (int i = 0; i < 34; i++) rstep(0, 31);

        // Final random run.
        for (int i = 0; i < 300; i++) rstep(($urandom_range(63, 0) == 0), 15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file. It is the next-generation register file for the multi-cycle MIPS datapath and its successors. It adds configurable width, depth and port counts, an optional hardwired zero register, and same-cycle write-to-read bypass. It also adds a sequenced initialisation engine with a ready flag, and write-conflict detection with a saturating counter. Reads are combinational; writes, initialisation and status are clocked.

Parameters:
DATA_W, 32, data width per register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
R0_ZERO, 1, 1: entry 0 reads as 0 and ignores writes
INIT_MODE, 1, 0: init value 0; 1: init value = entry index, zero-extended/truncated to DATA_W
BYPASS, 1, 1: same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
init_req  in  1  request re-initialisation while ready
ra  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
we  in  NUM_WR  write enables; bit j for port j
wa  in  NUM_WR*ADDR_W  write addresses, packed as for ra
wd  in  NUM_WR*DATA_W  write data, packed as for rd
ready  out  1  1 = array initialised; accesses honoured
wr_conflict  out  1  registered one-cycle pulse on a write-address collision
conflict_cnt  out  8  saturating count of collisions since init

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- States: INIT, RUN. A 2-bit state register is sufficient.
- Reset (rst=1 at posedge):
  - state=INIT, ptr=0, ready=0, wr_conflict=0, conflict_cnt=0.
  - Array contents are not cleared by the reset edge itself.
- INIT:
  - Each cycle: entry[ptr] <= init value; ptr <= ptr+1.
  - After the cycle that writes entry DEPTH-1: state=RUN, ready=1.
  - ready is therefore first high DEPTH cycles after the first posedge with rst=0.
  - With R0_ZERO=1, entry 0 is still written but always reads 0.
- During INIT (ready=0):
  - we and init_req are ignored.
  - All rd ports drive 0.
  - wr_conflict stays 0.
- RUN, writes:
  - Port j with we[j]=1 writes wd[j] to entry wa[j] at posedge.
  - With R0_ZERO=1, a write to address 0 is dropped.
- RUN, write conflict:
  - Both ports enabled with equal wa (NUM_WR=2): port 1 wins.
  - wr_conflict=1 for exactly the next cycle.
  - conflict_cnt increments, saturating at 255.
  - A collision on address 0 with R0_ZERO=1 still counts as a conflict.
- RUN, reads: rd[k] = entry[ra[k]] combinationally. With R0_ZERO=1 and ra[k]=0, rd[k]=0.
- RUN, bypass:
  - With BYPASS=1 and an enabled write port whose wa equals ra[k] (non-zero if R0_ZERO), rd[k]=wd of the highest-index matching port in the same cycle.
  - With BYPASS=0, rd[k] returns the pre-write value until the next cycle.
- Re-initialisation:
  - init_req=1 in RUN: any writes presented that cycle are discarded.
  - Next state=INIT, ptr=0, ready=0, conflict_cnt=0.
- rst asserted mid-INIT: ptr restarts at 0 and the full DEPTH-cycle sequence repeats.
- Simultaneous rst and init_req: rst dominates.

Test Plan:
- Defaults, rst for 1 cycle then low: ready stays 0 for 32 cycles, then 1. rd for ra=5,31 returns 5 and 31; ra=0 returns 0.
- RUN, we=01, wa0=7, wd0=0xDEADBEEF, ra0=7:
  - BYPASS=1: rd0=0xDEADBEEF in the same cycle.
  - BYPASS=0: rd0=7 that cycle and 0xDEADBEEF next cycle.
- we=11, wa0=wa1=9, wd0=0x1, wd1=0x2: entry 9 reads 0x2. wr_conflict pulses high 1 cycle. conflict_cnt=1. After 300 such collisions, conflict_cnt=255.
- R0_ZERO=1, write 0xFFFF_FFFF to address 0: rd at ra=0 stays 0, including in the same cycle with BYPASS=1.
- After writing entry 3=0xAA, pulse init_req: ready falls next cycle. Writes during INIT are ignored. After 32 cycles, entry 3 reads 3 and conflict_cnt=0.
- rst asserted at INIT cycle 10: ready reasserts exactly 32 cycles after rst deasserts. INIT_MODE=0 build: all entries read 0.
